noc_tx_ni: RTL and testbench



---
 rtl/noc_pkg.sv | 58 +++++
 rtl/noc_tx_ni_if.sv | 24 ++
 rtl/noc_sync_fifo.sv | 60 ++++++
 rtl/noc_tx_ni.sv | 102 ++++++++++
 tb/tb_noc_tx_ni.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the NOC tree network interfaces: node addresses,
// packet types, the 32-bit packet layout and the transmit FSM states.
package noc_pkg;

    localparam int NOC_W = 32;

    localparam logic [2:0] ADDR_MEM = 3'b000;
    localparam logic [2:0] ADDR_PE1 = 3'b001;
    localparam logic [2:0] ADDR_PE2 = 3'b010;
    localparam logic [2:0] ADDR_PE3 = 3'b011;
    localparam logic [2:0] ADDR_ADD = 3'b100;

    localparam int DEST_LSB    = 29;
    localparam int SRC_LSB     = 26;
    localparam int TYPE_LSB    = 24;
    localparam int SEQ_LSB     = 16;
    localparam int PAYLOAD_LSB = 0;

    typedef enum logic [1:0] {
        PKT_READ   = 2'b00,
        PKT_WRITE  = 2'b01,
        PKT_DATA   = 2'b10,
        PKT_RESULT = 2'b11
    } pkt_type_e;

    typedef struct packed {
        logic [2:0]  dest;
        logic [2:0]  src;
        pkt_type_e   ptype;
        logic [7:0]  seq;
        logic [15:0] payload;
    } noc_pkt_t;

    // What the node hands over; the source address and sequence number are added at launch.
    typedef struct packed {
        logic [2:0]  dest;
        pkt_type_e   ptype;
        logic [15:0] payload;
    } tx_entry_t;

    typedef enum logic {
        TX_IDLE,
        TX_WAIT
    } tx_state_e;

    function automatic noc_pkt_t make_pkt(input logic [2:0] dest, input logic [2:0] src,
                                          input pkt_type_e ptype, input logic [7:0] seq,
                                          input logic [15:0] payload);
        noc_pkt_t p;
        p.dest    = dest;
        p.src     = src;
        p.ptype   = ptype;
        p.seq     = seq;
        p.payload = payload;
        return p;
    endfunction

endpackage

// File: rtl/noc_tx_ni_if.sv
// Node-side word handshake plus the 2-phase bundled-data channel to the router.
interface noc_tx_ni_if;
    import noc_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_dest;
    logic [1:0]       in_type;
    logic [15:0]      in_data;
    logic             out_req;
    logic [NOC_W-1:0] out_data;
    logic             out_ack;

    modport master (
        output in_valid, in_dest, in_type, in_data, out_ack,
        input  in_ready, out_req, out_data
    );

    modport slave (
        input  in_valid, in_dest, in_type, in_data, out_ack,
        output in_ready, out_req, out_data
    );

endinterface

// File: rtl/noc_sync_fifo.sv
// Single-clock FIFO with registered count; shared by the transmit and receive
// network interfaces. DEPTH must be a power of two so the pointers wrap naturally.
module noc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/noc_tx_ni.sv
// Transmit network interface: queues node words, formats them into tree packets
// and launches one packet at a time on the 2-phase req/ack channel.
module noc_tx_ni
    import noc_pkg::*;
#(
    parameter logic [2:0] SRC_ADDR = 3'b001,
    parameter int         DEPTH    = 4,
    parameter int         SEQ_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    noc_tx_ni_if.slave bus,
    output logic       busy,
    output logic       drop_pulse
);

    localparam int CW = $clog2(DEPTH) + 1;

    tx_entry_t        push_entry;
    tx_entry_t        head_entry;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic             accept;
    logic             push;
    logic             pop;
    logic             load;
    tx_state_e        state_q;
    tx_state_e        state_d;
    logic             req_q;
    logic [NOC_W-1:0] data_q;
    logic [SEQ_W-1:0] seq_q;
    logic             drop_q;

    // Words addressed to this node are accepted but never enter the queue.
    assign accept      = bus.in_valid && !fifo_full;
    assign push        = accept && (bus.in_dest != SRC_ADDR);
    assign push_entry  = '{dest: bus.in_dest, ptype: pkt_type_e'(bus.in_type), payload: bus.in_data};

    assign bus.in_ready = !fifo_full;
    assign bus.out_req  = req_q;
    assign bus.out_data = data_q;
    assign drop_pulse   = drop_q;
    assign busy         = (fifo_count != '0) || (req_q != bus.out_ack);

    noc_sync_fifo #(
        .WIDTH ($bits(tx_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        load    = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    state_d = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (bus.out_ack == req_q) begin
                    state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // out_data only changes together with a req toggle, so it holds while req != ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TX_IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            seq_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= accept && (bus.in_dest == SRC_ADDR);
            if (load) begin
                data_q <= make_pkt(head_entry.dest, SRC_ADDR, head_entry.ptype,
                                   seq_q, head_entry.payload);
                req_q  <= ~req_q;
                seq_q  <= seq_q + SEQ_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_noc_tx_ni.sv
// Directed bench for noc_tx_ni: a router model echoes req onto ack and records
// every launched packet; each step compares against hand-computed values.
module tb_noc_tx_ni;
    import noc_pkg::*;

    logic        clk;
    logic        rst;
    logic        busy;
    logic        drop_pulse;
    int          checks;
    int          failures;
    int          stable_err;
    bit          ack_en;
    logic        last_req;
    logic [31:0] held;
    logic [31:0] pkts [$];
    int          accepted;

    noc_tx_ni_if bus ();

    noc_tx_ni #(
        .SRC_ADDR (ADDR_PE1),
        .DEPTH    (4),
        .SEQ_W    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .drop_pulse (drop_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Router model: records each new packet, watches that data holds while a
    // packet is outstanding, and echoes req onto ack when enabled.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            bus.out_ack = 1'b0;
            last_req    = 1'b0;
        end else begin
            if (bus.out_req != last_req) begin
                pkts.push_back(bus.out_data);
                held     = bus.out_data;
                last_req = bus.out_req;
            end else if ((bus.out_req != bus.out_ack) && (bus.out_data != held)) begin
                stable_err++;
            end
            if (ack_en) begin
                bus.out_ack = bus.out_req;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic resetDut();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pkts.delete();
        @(negedge clk);
    endtask

    // Offers one word, holds it until accepted, returns on the negedge after the accepting edge.
    task automatic applyStimulus(input logic [2:0] dest, input pkt_type_e ptype,
                                 input logic [15:0] data);
        int n;
        n            = 0;
        bus.in_valid = 1'b1;
        bus.in_dest  = dest;
        bus.in_type  = ptype;
        bus.in_data  = data;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("accept_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        stable_err   = 0;
        ack_en       = 1'b1;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_dest  = 3'b000;
        bus.in_type  = 2'b00;
        bus.in_data  = 16'h0000;

        $display("[TB] reset values");
        resetDut();
        checkOutput("rst_out_req", {31'd0, bus.out_req}, 32'd0);
        checkOutput("rst_out_data", bus.out_data, 32'h0000_0000);
        checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_drop", {31'd0, drop_pulse}, 32'd0);

        $display("[TB] two writes to ADD, latency and seq");
        applyStimulus(ADDR_ADD, PKT_WRITE, 16'hABCD);
        checkOutput("lat_req_before", {31'd0, bus.out_req}, 32'd0);
        checkOutput("lat_busy_queued", {31'd0, busy}, 32'd1);
        @(negedge clk);
        checkOutput("lat_req_toggle", {31'd0, bus.out_req}, 32'd1);
        checkOutput("pkt0_data", bus.out_data, 32'h8500_ABCD);
        applyStimulus(ADDR_ADD, PKT_WRITE, 16'h1234);
        waitIdle();
        checkOutput("t1_count", pkts.size(), 32'd2);
        checkOutput("t1_pkt1", pkts[1], 32'h8501_1234);
        checkOutput("t1_req_final", {31'd0, bus.out_req}, 32'd0);

        $display("[TB] read to MEM, busy falls with ack");
        resetDut();
        applyStimulus(ADDR_MEM, PKT_READ, 16'h0040);
        checkOutput("t2_busy_queued", {31'd0, busy}, 32'd1);
        @(negedge clk);
        checkOutput("t2_data", bus.out_data, 32'h0400_0040);
        checkOutput("t2_dest_field", {29'd0, bus.out_data[DEST_LSB +: 3]}, {29'd0, ADDR_MEM});
        checkOutput("t2_busy_after_ack", {31'd0, busy}, 32'd0);

        $display("[TB] ack held, FIFO fill and drain");
        ack_en = 1'b0;
        resetDut();
        accepted     = 0;
        bus.in_valid = 1'b1;
        bus.in_dest  = ADDR_ADD;
        bus.in_type  = PKT_DATA;
        for (int i = 0; i < 6; i++) begin
            bus.in_data = 16'h1000 + 16'(i);
            if (bus.in_ready) accepted++;
            @(negedge clk);
        end
        checkOutput("t3_accepted", accepted, 32'd5);
        checkOutput("t3_ready_low", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("t3_busy", {31'd0, busy}, 32'd1);
        checkOutput("t3_inflight", bus.out_data, 32'h8600_1000);
        bus.in_valid = 1'b0;
        ack_en       = 1'b1;
        waitIdle();
        checkOutput("t3_count", pkts.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("t3_pkt%0d", i), pkts[i],
                        {3'b100, 3'b001, 2'b10, 8'(i), 16'h1000 + 16'(i)});
        end
        checkOutput("t3_ready_back", {31'd0, bus.in_ready}, 32'd1);

        $display("[TB] 257 packets, seq wrap");
        resetDut();
        for (int i = 0; i < 257; i++) begin
            applyStimulus(ADDR_PE3, PKT_READ, 16'(i));
        end
        waitIdle();
        checkOutput("t4_count", pkts.size(), 32'd257);
        checkOutput("t4_pkt255", pkts[255], 32'h64FF_00FF);
        checkOutput("t4_pkt256", pkts[256], 32'h6400_0100);
        checkOutput("t4_seq256", {24'd0, pkts[256][SEQ_LSB +: 8]}, 32'h0000_0000);
        checkOutput("t4_src", {29'd0, pkts[100][SRC_LSB +: 3]}, {29'd0, ADDR_PE1});

        $display("[TB] self-addressed drop");
        resetDut();
        applyStimulus(ADDR_ADD, PKT_WRITE, 16'h5555);
        checkOutput("t5_no_drop", {31'd0, drop_pulse}, 32'd0);
        applyStimulus(ADDR_PE1, PKT_WRITE, 16'h9999);
        checkOutput("t5_drop_high", {31'd0, drop_pulse}, 32'd1);
        @(negedge clk);
        checkOutput("t5_drop_low", {31'd0, drop_pulse}, 32'd0);
        applyStimulus(ADDR_PE2, PKT_WRITE, 16'hAAAA);
        waitIdle();
        checkOutput("t5_count", pkts.size(), 32'd2);
        checkOutput("t5_pkt0", pkts[0], 32'h8500_5555);
        checkOutput("t5_pkt1", pkts[1], 32'h4501_AAAA);
        checkOutput("t5_type", {30'd0, pkts[1][TYPE_LSB +: 2]}, {30'd0, PKT_WRITE});

        $display("[TB] reset while waiting with 3 queued");
        ack_en = 1'b0;
        resetDut();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(ADDR_ADD, PKT_DATA, 16'h2000 + 16'(i));
        end
        checkOutput("t6_pre_req", {31'd0, bus.out_req}, 32'd1);
        checkOutput("t6_pre_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("t6_req", {31'd0, bus.out_req}, 32'd0);
        checkOutput("t6_data", bus.out_data, 32'h0000_0000);
        checkOutput("t6_busy", {31'd0, busy}, 32'd0);
        checkOutput("t6_ready", {31'd0, bus.in_ready}, 32'd1);
        ack_en = 1'b1;
        pkts.delete();
        @(negedge clk);
        applyStimulus(ADDR_MEM, PKT_RESULT, 16'h7777);
        waitIdle();
        checkOutput("t6_count", pkts.size(), 32'd1);
        checkOutput("t6_pkt0", pkts[0], 32'h0700_7777);
        checkOutput("t6_payload", {16'd0, pkts[0][PAYLOAD_LSB +: 16]}, 32'h0000_7777);

        checkOutput("data_stable", stable_err, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
